fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl_if.sv | 13 +
 rtl/fft_frame_ctrl.sv | 111 +++++++++++
 tb/tb_fft_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: valid/ready sample stream with complex payload and frame markers
interface fft_frame_ctrl_if #(
  parameter int W = 16
);
  logic valid;
  logic ready;
  logic first;
  logic last;
  logic [W-1:0] re;
  logic [W-1:0] im;
  modport master(output valid, re, im, first, last, input ready);
  modport slave(input valid, re, im, last, output ready);
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames a sample stream into an enable-gated FFT stage pipeline and forwards its results; FFT_FRAME_CTRL_STATS_EN adds frame/short counters
module fft_frame_ctrl #(
  parameter int WIDTH = 16,
  parameter int N = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_frame_ctrl_if.slave  s,
  fft_frame_ctrl_if.master m,
  output logic             p_valid,
  output logic             p_clk_en,
  output logic [WIDTH-1:0] p_real,
  output logic [WIDTH-1:0] p_imag,
  input  logic             pr_valid,
  input  logic [WIDTH:0]   pr_real,
  input  logic [WIDTH:0]   pr_imag,
  output logic             busy,
  output logic             err_short,
  output logic             err_timeout,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      short_cnt
);
  localparam int CW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, PAD, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] in_cnt, in_n, out_cnt, out_n;
  logic [WW-1:0] wd, wd_n;
  logic accept, xfer, set_short, set_to;
  assign p_clk_en = ~pr_valid | m.ready;
  assign s.ready = p_clk_en & ((state == IDLE) | (state == LOAD));
  assign accept = s.valid & s.ready;
  assign xfer = pr_valid & m.ready;
  assign m.valid = pr_valid;
  assign m.re = pr_real;
  assign m.im = pr_imag;
  assign m.first = pr_valid & (out_cnt == '0);
  assign m.last = pr_valid & (out_cnt == CW'(N - 1));
  assign busy = state != IDLE;
  // next state and counters; counters are log2(N) wide so they wrap to 0 exactly at frame end
  always_comb begin
    state_n = state;
    in_n = in_cnt;
    out_n = out_cnt;
    wd_n = wd;
    set_short = 1'b0;
    set_to = 1'b0;
    p_valid = accept | (state == PAD);
    p_real = accept ? s.re : '0;
    p_imag = accept ? s.im : '0;
    if (p_clk_en)
      case (state)
        IDLE, LOAD: if (accept) begin
          in_n = in_cnt + 1'b1;
          if (state == LOAD && in_cnt == CW'(N - 1)) state_n = DRAIN;
          else begin
            state_n = s.last ? PAD : LOAD;
            set_short = s.last;
          end
        end
        PAD: begin
          in_n = in_cnt + 1'b1;
          state_n = (in_cnt == CW'(N - 1)) ? DRAIN : PAD;
        end
        DRAIN: if (xfer) begin
          wd_n = '0;
          out_n = out_cnt + 1'b1;
          state_n = (out_cnt == CW'(N - 1)) ? IDLE : DRAIN;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          set_to = 1'b1;
          wd_n = '0;
          out_n = '0;
          state_n = IDLE;
        end else wd_n = wd + 1'b1;
      endcase
  end
  // state register; stalled cycles hold because next values equal current ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_cnt <= '0;
      out_cnt <= '0;
      wd <= '0;
      err_short <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      in_cnt <= in_n;
      out_cnt <= out_n;
      wd <= wd_n;
      err_short <= err_short | set_short;
      err_timeout <= err_timeout | set_to;
    end
`ifdef FFT_FRAME_CTRL_STATS_EN
  logic done;
  assign done = xfer & (state == DRAIN) & (out_cnt == CW'(N - 1));
  // wrapping statistics of completed frames and short-frame entries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_cnt <= '0;
      short_cnt <= '0;
    end else begin
      if (done) frame_cnt <= frame_cnt + 1'b1;
      if (set_short) short_cnt <= short_cnt + 1'b1;
    end
`else
  assign frame_cnt = '0;
  assign short_cnt = '0;
`endif
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: frame-level model and scoreboard checking fft_frame_ctrl against a stub stage pipeline
module tb_fft_frame_ctrl;
  localparam int WIDTH = 16;
  localparam int N = 8;
  localparam int TIMEOUT = 64;
`ifdef FFT_FRAME_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p_valid, p_clk_en, busy, err_short, err_timeout;
  logic [WIDTH-1:0] p_real, p_imag;
  logic pr_valid = 1'b0;
  logic [WIDTH:0] pr_real = '0;
  logic [WIDTH:0] pr_imag = '0;
  logic [15:0] frame_cnt, short_cnt;
  int checks = 0;
  int errors = 0;
  fft_frame_ctrl_if #(.W(WIDTH)) s_if();
  fft_frame_ctrl_if #(.W(WIDTH + 1)) m_if();

  fft_frame_ctrl #(.WIDTH(WIDTH), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if),
    .p_valid(p_valid), .p_clk_en(p_clk_en), .p_real(p_real), .p_imag(p_imag),
    .pr_valid(pr_valid), .pr_real(pr_real), .pr_imag(pr_imag),
    .busy(busy), .err_short(err_short), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt), .short_cnt(short_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // pipeline butterfly stand-in: result = (a+b, a-b) at one extra bit
  function automatic logic [2*WIDTH+1:0] f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r, i;
    r = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    i = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return {r, i};
  endfunction

  // stage pipeline stub: collects a full frame, then releases results, frozen when p_clk_en=0
  bit dead = 1'b0;
  logic [2*WIDTH+1:0] inq[$];
  logic [2*WIDTH+1:0] outq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inq.delete();
      outq.delete();
      pr_valid <= 1'b0;
    end else if (p_clk_en) begin
      if (outq.size() > 0) begin
        pr_valid <= 1'b1;
        {pr_real, pr_imag} <= outq.pop_front();
      end else pr_valid <= 1'b0;
      if (p_valid && !dead) begin
        inq.push_back(f(p_real, p_imag));
        if (inq.size() == N) begin
          foreach (inq[k]) outq.push_back(inq[k]);
          inq.delete();
        end
      end
    end
  end

  // downstream ready: fixed pattern plus an optional one-shot stall once results appear
  int stall_req = 0;
  logic [7:0] pat_mr = 8'hFF;
  logic [2:0] cyc = '0;
  always @(posedge clk) begin
    #1;
    if (stall_req > 0 && pr_valid) begin
      m_if.ready = 1'b0;
      stall_req--;
    end else m_if.ready = pat_mr[cyc];
    cyc++;
  end

  // frame model: samples fed into the frame in flight, pending pad zeros, results returned
  int fed, pad_left, ret, idle, frames, shorts;
  bit err_sh, err_to, prev_stall;
  logic [2*WIDTH+1:0] prev_m;
  logic [2*WIDTH+1:0] exp_q[$];
  int xfer_n, first_n, last_n, pad_n, drain_n, stall_n;

  always @(negedge clk) begin : cmp
    bit en, rdy, acc, ep;
    logic [2*WIDTH+1:0] e;
    if (!rst_n) begin
      fed = 0; pad_left = 0; ret = 0; idle = 0; frames = 0; shorts = 0;
      err_sh = 0; err_to = 0; prev_stall = 0;
      exp_q.delete();
    end
    en = !pr_valid || m_if.ready;
    rdy = en && fed < N && pad_left == 0;
    acc = rdy && s_if.valid;
    ep = acc || pad_left > 0;
    chk("p_clk_en", p_clk_en, en);
    chk("s_ready", s_if.ready, rdy);
    chk("p_valid", p_valid, ep);
    if (ep) chk("p_data", {p_real, p_imag}, acc ? {s_if.re, s_if.im} : 32'h0);
    chk("busy", busy, fed > 0);
    chk("m_pass", {m_if.valid, m_if.re, m_if.im}, {pr_valid, pr_real, pr_imag});
    chk("m_first", m_if.first, pr_valid && ret == 0);
    chk("m_last", m_if.last, pr_valid && ret == N - 1);
    chk("err_short", err_short, err_sh);
    chk("err_timeout", err_timeout, err_to);
    chk("frame_cnt", frame_cnt, STATS ? 16'(frames) : 16'h0);
    chk("short_cnt", short_cnt, STATS ? 16'(shorts) : 16'h0);
    if (prev_stall) chk("m_hold", {m_if.valid, m_if.re, m_if.im}, {1'b1, prev_m});
    prev_stall = rst_n && m_if.valid && !m_if.ready;
    prev_m = {m_if.re, m_if.im};
    if (rst_n) begin
      if (m_if.valid && m_if.ready) begin
        xfer_n++;
        if (m_if.first) first_n++;
        if (m_if.last) last_n++;
      end
      if (p_valid && p_clk_en && !(s_if.valid && s_if.ready)) pad_n++;
      if (busy && !s_if.ready) drain_n++;
      if (m_if.valid && !m_if.ready) stall_n++;
    end
    if (rst_n && en) begin
      if (fed == N) begin
        if (pr_valid) begin
          chk("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("m_data", {m_if.re, m_if.im}, e);
          end
          ret++;
          idle = 0;
          if (ret == N) begin fed = 0; ret = 0; frames++; end
        end else begin
          idle++;
          if (idle == TIMEOUT) begin
            fed = 0; ret = 0; idle = 0; err_to = 1;
            exp_q.delete();
          end
        end
      end else if (acc) begin
        fed++;
        exp_q.push_back(f(s_if.re, s_if.im));
        if (s_if.last && fed < N) begin
          pad_left = N - fed;
          err_sh = 1;
          shorts++;
        end
      end else if (pad_left > 0) begin
        pad_left--;
        fed++;
        exp_q.push_back(f('0, '0));
      end
    end
  end

  task automatic clear_counts();
    xfer_n = 0; first_n = 0; last_n = 0; pad_n = 0; drain_n = 0; stall_n = 0;
  endtask

  task automatic hs();
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = s_if.ready;
      @(posedge clk);
      #1;
    end
    chk("handshake", ok, 1);
  endtask

  task automatic send(input int t, input int n, input int last_at, input int gap);
    for (int i = 0; i < n; i++) begin
      s_if.valid = 1'b1;
      s_if.re = WIDTH'(t * 1000 + i * 37 + 5);
      s_if.im = WIDTH'(-(t * 11) - i * 7);
      s_if.last = (i == last_at);
      hs();
      s_if.valid = 1'b0;
      s_if.last = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk(nm, ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_if.valid = 1'b0; s_if.re = '0; s_if.im = '0; s_if.last = 1'b0; s_if.first = 1'b0;
    clear_counts();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_if.ready, 1);
    chk("rst_errs", {err_short, err_timeout}, 0);
    chk("rst_stats", {frame_cnt, short_cnt}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send(1, 8, -1, 0);
    wait_idle("t1_idle");
    chk("t1_results", xfer_n, 8);
    chk("t1_first", first_n, 1);
    chk("t1_last", last_n, 1);
    chk("t1_frames", frame_cnt, STATS ? 1 : 0);
    clear_counts();
    send(2, 3, 2, 0);
    wait_idle("t2_idle");
    chk("t2_pad", pad_n, 5);
    chk("t2_err_short", err_short, 1);
    chk("t2_results", xfer_n, 8);
    chk("t2_shorts", short_cnt, STATS ? 1 : 0);
    clear_counts();
    stall_req = 5;
    send(3, 8, -1, 0);
    wait_idle("t3_idle");
    chk("t3_stall", stall_n, 5);
    chk("t3_results", xfer_n, 8);
    clear_counts();
    pat_mr = 8'b0110_1101;
    send(4, 8, -1, 2);
    wait_idle("t4_idle");
    pat_mr = 8'hFF;
    chk("t4_results", xfer_n, 8);
    chk("t4_frames", frame_cnt, STATS ? 4 : 0);
    clear_counts();
    dead = 1'b1;
    send(5, 8, -1, 0);
    wait_idle("t5_idle");
    dead = 1'b0;
    chk("t5_drain", drain_n, 64);
    chk("t5_err_timeout", err_timeout, 1);
    chk("t5_s_ready", s_if.ready, 1);
    chk("t5_results", xfer_n, 0);
    clear_counts();
    send(6, 5, -1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_async_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_s_ready", s_if.ready, 1);
    chk("t6_errs", {err_short, err_timeout}, 0);
    @(posedge clk); #1;
    send(7, 8, -1, 0);
    wait_idle("t7_idle");
    chk("t7_results", xfer_n, 8);
    chk("t7_frames", frame_cnt, STATS ? 1 : 0);
    send(8, 8, -1, 1);
    wait_idle("t8_idle");
    send(9, 4, 3, 0);
    wait_idle("t9_idle");
    chk("t9_frames", frame_cnt, STATS ? 3 : 0);
    chk("t9_shorts", short_cnt, STATS ? 1 : 0);
    chk("t9_results", xfer_n, 24);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
